regfile_writeback: RTL and testbench



---
 rtl/regfile_writeback_pkg.sv | 13 +
 rtl/regfile_writeback_if.sv | 22 ++
 rtl/regfile_writeback_fifo.sv | 48 ++++
 rtl/regfile_writeback.sv | 64 ++++++
 tb/tb_regfile_writeback.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_writeback_pkg.sv
// regfile_writeback_pkg: shared types and helpers for the register-file write-back path
package regfile_writeback_pkg;
    localparam int NUM_REGS = 32;
    localparam int RD_W = 5;
    typedef logic [31:0] bus_type;
    typedef struct packed {
        logic [RD_W-1:0] rd;
        bus_type         data;
    } wb_entry_t;
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [RD_W-1:0] rd);
        return NUM_REGS'(1) << rd;
    endfunction
endpackage

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: producer handshakes and register-file write port
interface regfile_writeback_if #(parameter int XLEN = 32);
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic [4:0]      rf_write_addr;
    logic [XLEN-1:0] rf_input_data;
    logic            rf_enable;
    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output alu_ready, ld_ready, rf_write_addr, rf_input_data, rf_enable
    );
    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  alu_ready, ld_ready, rf_write_addr, rf_input_data, rf_enable
    );
endinterface

// File: rtl/regfile_writeback_fifo.sv
// regfile_writeback_fifo: circular buffer of write-back entries, exposed oldest-first for scans
module regfile_writeback_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  wb_entry_t        entry_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output wb_entry_t        head_o,
    output wb_entry_t        age_o [DEPTH],
    output logic [DEPTH-1:0] age_valid_o
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;
    wb_entry_t     mem_q [DEPTH];
    logic          do_push, do_pop;
    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= entry_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
    // Index k is the k-th oldest entry, so the highest valid k is the youngest.
    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        assign age_o[g]       = mem_q[rd_q + PW'(g)];
        assign age_valid_o[g] = (PW+1)'(g) < cnt_q;
    end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates ALU/load results into an in-order queue draining to the register file
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_writeback_if.slave   wb,
    output logic [NUM_REGS-1:0]  busy_mask_o,
    input  logic [RD_W-1:0]      byp_addr_i,
    output logic                 byp_hit_o,
    output logic [XLEN-1:0]      byp_data_o,
    output logic                 idle_o
);
    logic             rr_q, rr_d;
    logic             ld_gnt, alu_gnt, push, full, empty;
    wb_entry_t        entry, head;
    wb_entry_t        age [DEPTH];
    logic [DEPTH-1:0] age_valid;
    // rr_q high means the load unit wins the next contention cycle.
    assign ld_gnt  = rst_n && !full && wb.ld_valid && (rr_q || !wb.alu_valid);
    assign alu_gnt = rst_n && !full && wb.alu_valid && !ld_gnt;
    assign rr_d    = ld_gnt ? 1'b0 : alu_gnt ? 1'b1 : rr_q;
    assign wb.ld_ready  = ld_gnt;
    assign wb.alu_ready = alu_gnt;
    assign entry = ld_gnt ? wb_entry_t'{rd: wb.ld_rd, data: wb.ld_data}
                          : wb_entry_t'{rd: wb.alu_rd, data: wb.alu_data};
    assign push  = (ld_gnt && wb.ld_rd != '0) || (alu_gnt && wb.alu_rd != '0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= 1'b1;
        else        rr_q <= rr_d;
    end
    regfile_writeback_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .entry_i     (entry),
        .pop_i       (!empty),
        .full_o      (full),
        .empty_o     (empty),
        .head_o      (head),
        .age_o       (age),
        .age_valid_o (age_valid)
    );
    assign wb.rf_enable     = !empty;
    assign wb.rf_write_addr = empty ? '0 : head.rd;
    assign wb.rf_input_data = empty ? '0 : head.data;
    assign idle_o           = empty;
    always_comb begin
        busy_mask_o = '0;
        byp_hit_o   = 1'b0;
        byp_data_o  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            busy_mask_o = age_valid[k] ? busy_mask_o | rd_onehot(age[k].rd) : busy_mask_o;
            if (age_valid[k] && byp_addr_i != '0 && age[k].rd == byp_addr_i) begin
                byp_hit_o  = 1'b1;
                byp_data_o = age[k].data;
            end
        end
        busy_mask_o[0] = 1'b0;
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed scenarios for the register-file write-back queue
module tb_regfile_writeback;
    import regfile_writeback_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] busy;
    logic [4:0]  byp_addr;
    logic        byp_hit;
    logic [31:0] byp_data;
    logic        idle;
    logic [36:0] wlog [$];
    logic [36:0] exp_w;
    int          n_cmp = 0;
    int          n_err = 0;

    regfile_writeback_if #(.XLEN(32)) bus ();

    regfile_writeback #(.DEPTH(4), .XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb          (bus),
        .busy_mask_o (busy),
        .byp_addr_i  (byp_addr),
        .byp_hit_o   (byp_hit),
        .byp_data_o  (byp_data),
        .idle_o      (idle)
    );

    always #5 clk = ~clk;

    // Each negedge with rf_enable high is a write the next rising edge commits.
    always @(negedge clk) if (rst_n && bus.rf_enable) wlog.push_back({bus.rf_write_addr, bus.rf_input_data});

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #3;
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        bus.alu_valid = av;
        bus.alu_rd    = ar;
        bus.alu_data  = ad;
        bus.ld_valid  = lv;
        bus.ld_rd     = lr;
        bus.ld_data   = ld;
    endtask

    task automatic test_reset;
        byp_addr = 5'd0;
        drive(1'b1, 5'd5, 32'hAA, 1'b1, 5'd1, 32'h11);
        settle;
        n_cmp++; if (bus.alu_ready !== 1'b0) begin n_err++; $display("FAIL reset_alu_ready got=%0h exp=0", bus.alu_ready); end
        n_cmp++; if (bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL reset_ld_ready got=%0h exp=0", bus.ld_ready); end
        n_cmp++; if (bus.rf_enable !== 1'b0) begin n_err++; $display("FAIL reset_rf_enable got=%0h exp=0", bus.rf_enable); end
        n_cmp++; if (bus.rf_write_addr !== 5'd0) begin n_err++; $display("FAIL reset_rf_addr got=%0h exp=0", bus.rf_write_addr); end
        n_cmp++; if (bus.rf_input_data !== 32'd0) begin n_err++; $display("FAIL reset_rf_data got=%0h exp=0", bus.rf_input_data); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got=%0h exp=1", idle); end
        n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        wlog.delete();
        drive(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 32'd0);
        settle;
        n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL single_alu_ready got=%0h exp=1", bus.alu_ready); end
        n_cmp++; if (bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL single_ld_ready got=%0h exp=0", bus.ld_ready); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL single_idle_before got=%0h exp=1", idle); end
        tick;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle;
        n_cmp++; if (bus.rf_enable !== 1'b1) begin n_err++; $display("FAIL single_rf_enable got=%0h exp=1", bus.rf_enable); end
        n_cmp++; if (bus.rf_write_addr !== 5'd5) begin n_err++; $display("FAIL single_rf_addr got=%0h exp=5", bus.rf_write_addr); end
        n_cmp++; if (bus.rf_input_data !== 32'hAA) begin n_err++; $display("FAIL single_rf_data got=%0h exp=aa", bus.rf_input_data); end
        n_cmp++; if (busy !== 32'h20) begin n_err++; $display("FAIL single_busy got=%0h exp=20", busy); end
        n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL single_idle_during got=%0h exp=0", idle); end
        tick;
        settle;
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL single_idle_after got=%0h exp=1", idle); end
        n_cmp++; if (bus.rf_enable !== 1'b0) begin n_err++; $display("FAIL single_rf_enable_after got=%0h exp=0", bus.rf_enable); end
        n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL single_busy_after got=%0h exp=0", busy); end
        n_cmp++; if (wlog.size() !== 1) begin n_err++; $display("FAIL single_write_count got=%0d exp=1", wlog.size()); end
        else begin
            exp_w = {5'd5, 32'hAA};
            n_cmp++; if (wlog[0] !== exp_w) begin n_err++; $display("FAIL single_write got=%0h exp=%0h", wlog[0], exp_w); end
        end
    endtask

    task automatic test_round_robin;
        wlog.delete();
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd1, 32'h11);
        for (int i = 0; i < 4; i++) begin
            settle;
            n_cmp++; if (bus.ld_ready !== (i % 2 == 0)) begin n_err++; $display("FAIL rr_ld_ready[%0d] got=%0h exp=%0h", i, bus.ld_ready, i % 2 == 0); end
            n_cmp++; if (bus.alu_ready !== (i % 2 == 1)) begin n_err++; $display("FAIL rr_alu_ready[%0d] got=%0h exp=%0h", i, bus.alu_ready, i % 2 == 1); end
            if (i > 0) begin
                n_cmp++; if (busy !== ((i % 2 == 1) ? 32'h2 : 32'h4)) begin n_err++; $display("FAIL rr_busy[%0d] got=%0h", i, busy); end
            end
            tick;
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle;
        tick;
        settle;
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rr_idle got=%0h exp=1", idle); end
        n_cmp++; if (wlog.size() !== 4) begin n_err++; $display("FAIL rr_write_count got=%0d exp=4", wlog.size()); end
        else for (int j = 0; j < 4; j++) begin
            exp_w = (j % 2 == 0) ? {5'd1, 32'h11} : {5'd2, 32'h22};
            n_cmp++; if (wlog[j] !== exp_w) begin n_err++; $display("FAIL rr_write[%0d] got=%0h exp=%0h", j, wlog[j], exp_w); end
        end
    endtask

    task automatic test_x0;
        wlog.delete();
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
        settle;
        n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL x0_alu_ready got=%0h exp=1", bus.alu_ready); end
        tick;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle;
        n_cmp++; if (bus.rf_enable !== 1'b0) begin n_err++; $display("FAIL x0_rf_enable got=%0h exp=0", bus.rf_enable); end
        n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL x0_busy got=%0h exp=0", busy); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL x0_idle got=%0h exp=1", idle); end
        tick;
        n_cmp++; if (wlog.size() !== 0) begin n_err++; $display("FAIL x0_write_count got=%0d exp=0", wlog.size()); end
    endtask

    task automatic test_back_to_back;
        wlog.delete();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'(i));
            settle;
            n_cmp++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ld_ready[%0d] got=%0h exp=1", i, bus.ld_ready); end
            if (i > 1) begin
                n_cmp++; if (busy !== 32'h8) begin n_err++; $display("FAIL b2b_busy[%0d] got=%0h exp=8", i, busy); end
                n_cmp++; if (bus.rf_input_data !== 32'(i - 1)) begin n_err++; $display("FAIL b2b_head[%0d] got=%0h exp=%0h", i, bus.rf_input_data, i - 1); end
            end
            tick;
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle;
        tick;
        settle;
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL b2b_idle got=%0h exp=1", idle); end
        n_cmp++; if (wlog.size() !== 5) begin n_err++; $display("FAIL b2b_write_count got=%0d exp=5", wlog.size()); end
        else for (int j = 0; j < 5; j++) begin
            exp_w = {5'd3, 32'(j + 1)};
            n_cmp++; if (wlog[j] !== exp_w) begin n_err++; $display("FAIL b2b_write[%0d] got=%0h exp=%0h", j, wlog[j], exp_w); end
        end
    endtask

    task automatic test_bypass;
        byp_addr = 5'd7;
        drive(1'b1, 5'd7, 32'h10, 1'b0, 5'd0, 32'd0);
        settle;
        n_cmp++; if (byp_hit !== 1'b0) begin n_err++; $display("FAIL byp_incoming_hidden got=%0h exp=0", byp_hit); end
        tick;
        drive(1'b1, 5'd7, 32'h20, 1'b0, 5'd0, 32'd0);
        settle;
        n_cmp++; if (byp_hit !== 1'b1) begin n_err++; $display("FAIL byp_first_hit got=%0h exp=1", byp_hit); end
        n_cmp++; if (byp_data !== 32'h10) begin n_err++; $display("FAIL byp_first_data got=%0h exp=10", byp_data); end
        tick;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle;
        n_cmp++; if (byp_hit !== 1'b1) begin n_err++; $display("FAIL byp_second_hit got=%0h exp=1", byp_hit); end
        n_cmp++; if (byp_data !== 32'h20) begin n_err++; $display("FAIL byp_second_data got=%0h exp=20", byp_data); end
        byp_addr = 5'd0;
        #1;
        n_cmp++; if (byp_hit !== 1'b0) begin n_err++; $display("FAIL byp_x0_hit got=%0h exp=0", byp_hit); end
        n_cmp++; if (byp_data !== 32'd0) begin n_err++; $display("FAIL byp_x0_data got=%0h exp=0", byp_data); end
        tick;
        byp_addr = 5'd7;
        settle;
        n_cmp++; if (byp_hit !== 1'b0) begin n_err++; $display("FAIL byp_empty_hit got=%0h exp=0", byp_hit); end
    endtask

    task automatic test_reset_mid;
        wlog.delete();
        byp_addr = 5'd9;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
        settle;
        tick;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle;
        n_cmp++; if (bus.rf_enable !== 1'b1) begin n_err++; $display("FAIL rmid_rf_enable_pre got=%0h exp=1", bus.rf_enable); end
        n_cmp++; if (byp_hit !== 1'b1) begin n_err++; $display("FAIL rmid_byp_hit_pre got=%0h exp=1", byp_hit); end
        n_cmp++; if (busy !== 32'h200) begin n_err++; $display("FAIL rmid_busy_pre got=%0h exp=200", busy); end
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
        #1;
        n_cmp++; if (bus.rf_enable !== 1'b0) begin n_err++; $display("FAIL rmid_rf_enable got=%0h exp=0", bus.rf_enable); end
        n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL rmid_busy got=%0h exp=0", busy); end
        n_cmp++; if (byp_hit !== 1'b0) begin n_err++; $display("FAIL rmid_byp_hit got=%0h exp=0", byp_hit); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rmid_idle got=%0h exp=1", idle); end
        n_cmp++; if (bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL rmid_ld_ready got=%0h exp=0", bus.ld_ready); end
        tick;
        tick;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b1;
        settle;
        tick;
        settle;
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rmid_idle_after got=%0h exp=1", idle); end
        n_cmp++; if (wlog.size() !== 0) begin n_err++; $display("FAIL rmid_stale_writes got=%0d exp=0", wlog.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_x0;
        test_back_to_back;
        test_bypass;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
